// File: rtl/mii_rx_ctrl.sv
// mii_rx_ctrl: MII receive sequencer. Locks onto preamble/SFD, pairs nibbles
// into bytes (low nibble first), marks frame start/end and classifies each
// frame as good or bad by length, PHY error and nibble alignment.
module mii_rx_ctrl #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        E_RX_CLK,
  input  logic        RST_N,
  input  logic        E_RX_DV,
  input  logic [3:0]  E_RXD,
  input  logic        E_RX_ER,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic [10:0] rx_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [3:0]  NIB_PRE = 4'h5;
  localparam logic [3:0]  NIB_SFD = 4'hD;
  localparam logic [10:0] LEN_MIN = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);
  localparam logic [10:0] LEN_SAT = '1;

  typedef enum logic [2:0] {IDLE, PRE, DATA_LO, DATA_HI, DROP} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        start_frame;
  logic        take_lo;
  logic        emit_byte;
  logic        issue_eof;
  logic        dribble;
  logic        drop_done;
  logic        er_hit;
  logic        eof_bad;

  logic [3:0]  low_nib;
  logic [10:0] len_cnt;
  logic        err_flag;
  logic        sof_arm;

  // State register
  always_ff @(posedge E_RX_CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-cycle datapath strobes
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    take_lo     = 1'b0;
    emit_byte   = 1'b0;
    issue_eof   = 1'b0;
    dribble     = 1'b0;
    drop_done   = 1'b0;
    er_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (E_RX_DV) begin
          if (!E_RX_ER && (E_RXD == NIB_PRE)) state_nxt = PRE;
          else                                state_nxt = DROP;
        end
      end
      PRE: begin
        if (!E_RX_DV)              state_nxt = IDLE;
        else if (E_RX_ER)          state_nxt = DROP;
        else if (E_RXD == NIB_PRE) state_nxt = PRE;
        else if (E_RXD == NIB_SFD) begin
          state_nxt   = DATA_LO;
          start_frame = 1'b1;
        end
        else                       state_nxt = DROP;
      end
      DATA_LO: begin
        if (E_RX_DV) begin
          take_lo   = 1'b1;
          er_hit    = E_RX_ER;
          state_nxt = DATA_HI;
        end else begin
          issue_eof = 1'b1;
          state_nxt = IDLE;
        end
      end
      DATA_HI: begin
        if (E_RX_DV) begin
          emit_byte = 1'b1;
          er_hit    = E_RX_ER;
          state_nxt = DATA_LO;
        end else begin
          // half byte left over: frame ends misaligned
          issue_eof = 1'b1;
          dribble   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!E_RX_DV) begin
          drop_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame verdict at end of frame; dribble is folded in directly because the
  // sticky flag would only see it one cycle too late
  always_comb begin
    eof_bad = err_flag | dribble | (len_cnt < LEN_MIN) | (len_cnt > LEN_MAX);
  end

  // Per-frame tracking: low nibble holder, saturating length, sticky error, sof arm
  always_ff @(posedge E_RX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      low_nib  <= '0;
      len_cnt  <= '0;
      err_flag <= 1'b0;
      sof_arm  <= 1'b0;
    end else begin
      if (start_frame) begin
        len_cnt  <= '0;
        err_flag <= 1'b0;
        sof_arm  <= 1'b1;
      end
      if (take_lo) low_nib <= E_RXD;
      if (er_hit)  err_flag <= 1'b1;
      if (emit_byte) begin
        sof_arm <= 1'b0;
        if (len_cnt != LEN_SAT) len_cnt <= len_cnt + 11'd1;
      end
      if (issue_eof) sof_arm <= 1'b0;
    end
  end

  // Registered byte stream and end-of-frame status
  always_ff @(posedge E_RX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
      rx_len   <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      if (emit_byte) begin
        rx_data  <= {E_RXD, low_nib};
        rx_valid <= 1'b1;
        rx_sof   <= sof_arm;
      end
      if (issue_eof) begin
        rx_eof <= 1'b1;
        rx_len <= len_cnt;
        rx_err <= eof_bad;
      end
    end
  end

  // Good/bad frame counters; eof and drop completion are mutually exclusive
  always_ff @(posedge E_RX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (issue_eof) begin
        if (eof_bad) bad_cnt  <= bad_cnt + 16'd1;
        else         good_cnt <= good_cnt + 16'd1;
      end else if (drop_done) begin
        bad_cnt <= bad_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mii_rx_ctrl.sv
// tb_mii_rx_ctrl: drives nibble bursts into mii_rx_ctrl and compares the byte
// stream, frame markers and counters against a burst-level reference model.
`timescale 1ns/1ps
module tb_mii_rx_ctrl;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int LEN_SAT = 2047;

  logic        E_RX_CLK = 1'b0;
  logic        RST_N    = 1'b0;
  logic        E_RX_DV  = 1'b0;
  logic [3:0]  E_RXD    = 4'h0;
  logic        E_RX_ER  = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_err;
  logic [10:0] rx_len;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  mii_rx_ctrl #(
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .E_RX_CLK (E_RX_CLK),
    .RST_N    (RST_N),
    .E_RX_DV  (E_RX_DV),
    .E_RXD    (E_RXD),
    .E_RX_ER  (E_RX_ER),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_sof   (rx_sof),
    .rx_eof   (rx_eof),
    .rx_err   (rx_err),
    .rx_len   (rx_len),
    .good_cnt (good_cnt),
    .bad_cnt  (bad_cnt)
  );

  always #20 E_RX_CLK = ~E_RX_CLK;

  int unsigned cyc = 0;
  always @(posedge E_RX_CLK) cyc <= cyc + 1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Output monitor, sampled 1 ns after each rising edge
  logic [7:0]  got_bytes[$];
  int unsigned got_cyc[$];
  int          sof_idx[$];
  int          eof_n    = 0;
  logic        eof_err  = 1'b0;
  logic [10:0] eof_len  = '0;
  int unsigned eof_cyc  = 0;
  int          prot_err = 0;

  always @(posedge E_RX_CLK) begin
    #1;
    if (rx_valid) begin
      if (rx_sof) sof_idx.push_back(got_bytes.size());
      got_bytes.push_back(rx_data);
      got_cyc.push_back(cyc);
    end else if (rx_sof) begin
      prot_err++;
    end
    if (rx_eof) begin
      if (rx_valid) prot_err++;
      eof_n++;
      eof_err = rx_err;
      eof_len = rx_len;
      eof_cyc = cyc;
    end
  end

  // Burst store: every burst is a run of DV=1 nibbles followed by gap DV=0 cycles
  logic [3:0] bnib[$];
  bit         ber[$];
  int         b_off[$];
  int         b_len[$];
  int         b_gap[$];
  string      b_lbl[$];

  // Reference model results for one burst
  logic [7:0]  m_bytes[$];
  bit          m_eof;
  bit          m_err;
  int          m_len;
  int          m_d;
  bit          m_good;
  bit          m_bad;
  logic [15:0] good_m = '0;
  logic [15:0] bad_m  = '0;

  task automatic add_frame(input string lbl, input int npre, input int nbytes,
                           input bit rnd, input int er_at, input bit drib, input int gap);
    int off;
    logic [7:0] v;
    off = bnib.size();
    for (int i = 0; i < npre; i++) begin bnib.push_back(4'h5); ber.push_back(1'b0); end
    bnib.push_back(4'hD); ber.push_back(1'b0);
    for (int j = 0; j < nbytes; j++) begin
      v = rnd ? 8'($urandom) : 8'(j);
      bnib.push_back(v[3:0]); ber.push_back(1'b0);
      bnib.push_back(v[7:4]); ber.push_back(1'b0);
    end
    if (drib) begin bnib.push_back(4'hA); ber.push_back(1'b0); end
    if (er_at >= 0 && er_at < bnib.size() - off) ber[off + er_at] = 1'b1;
    b_off.push_back(off); b_len.push_back(bnib.size() - off);
    b_gap.push_back(gap); b_lbl.push_back(lbl);
  endtask

  task automatic add_nibs(input string lbl, input int n, input bit all5, input int gap);
    int off;
    off = bnib.size();
    for (int i = 0; i < n; i++) begin
      bnib.push_back(all5 ? 4'h5 : 4'($urandom));
      ber.push_back(all5 ? 1'b0 : ($urandom_range(0, 3) == 0));
    end
    b_off.push_back(off); b_len.push_back(n); b_gap.push_back(gap); b_lbl.push_back(lbl);
  endtask

  task automatic add_bad_pre(input string lbl, input int gap);
    int off;
    off = bnib.size();
    bnib.push_back(4'h5); ber.push_back(1'b0);
    bnib.push_back(4'h5); ber.push_back(1'b0);
    bnib.push_back(4'h3); ber.push_back(1'b0);
    b_off.push_back(off); b_len.push_back(3); b_gap.push_back(gap); b_lbl.push_back(lbl);
  endtask

  // Burst-level reference: strip 5s, require D, pair the rest, judge the frame
  task automatic model_burst(input int off, input int len);
    int i;
    int k;
    int nb;
    bit er_d;
    m_bytes.delete();
    m_eof = 0; m_err = 0; m_len = 0; m_d = 0; m_good = 0; m_bad = 0;
    if (len == 0) return;
    i = 0;
    while (i < len && bnib[off + i] == 4'h5 && !ber[off + i]) i++;
    if (i == len) return;
    if (i == 0 || ber[off + i] || bnib[off + i] != 4'hD) begin
      m_bad = 1;
      return;
    end
    m_d  = i + 1;
    k    = len - m_d;
    nb   = k / 2;
    er_d = 0;
    for (int j = m_d; j < len; j++) er_d |= ber[off + j];
    for (int j = 0; j < nb; j++) m_bytes.push_back({bnib[off + m_d + 2*j + 1], bnib[off + m_d + 2*j]});
    m_len  = (nb > LEN_SAT) ? LEN_SAT : nb;
    m_err  = er_d || (k % 2 == 1) || (m_len < MIN_LEN) || (m_len > MAX_LEN);
    m_eof  = 1;
    m_good = !m_err;
    m_bad  = m_err;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge E_RX_CLK);
    #1;
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset/rx_data: got %h, want 00", rx_data); end
    vectors++;
    if ({rx_valid, rx_sof, rx_eof, rx_err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset/flags: got %b, want 0000", {rx_valid, rx_sof, rx_eof, rx_err});
    end
    vectors++;
    if (rx_len !== 11'd0) begin miscompares++; $display("FAIL reset/rx_len: got %0d, want 0", rx_len); end
    vectors++;
    if (good_cnt !== 16'd0) begin miscompares++; $display("FAIL reset/good_cnt: got %0d, want 0", good_cnt); end
    vectors++;
    if (bad_cnt !== 16'd0) begin miscompares++; $display("FAIL reset/bad_cnt: got %0d, want 0", bad_cnt); end
    @(negedge E_RX_CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge E_RX_CLK);
  endtask

  task automatic test_frame_stream();
    int off, len, byte_base, sof_base, eof_base, prot_base, ngot, nexp, nbad, first_bad;
    int unsigned t_start, t_fall, exp_c;
    for (int b = 0; b < b_off.size(); b++) begin
      off = b_off[b];
      len = b_len[b];
      model_burst(off, len);
      good_m    = good_m + 16'(m_good);
      bad_m     = bad_m + 16'(m_bad);
      byte_base = got_bytes.size();
      sof_base  = sof_idx.size();
      eof_base  = eof_n;
      prot_base = prot_err;
      t_start   = 0;
      for (int i = 0; i < len; i++) begin
        @(negedge E_RX_CLK);
        if (i == 0) t_start = cyc;
        E_RX_DV = 1'b1;
        E_RXD   = bnib[off + i];
        E_RX_ER = ber[off + i];
      end
      @(negedge E_RX_CLK);
      E_RX_DV = 1'b0; E_RXD = 4'h0; E_RX_ER = 1'b0;
      t_fall = cyc;
      @(posedge E_RX_CLK);
      #2;

      ngot = got_bytes.size() - byte_base;
      nexp = m_bytes.size();
      vectors++;
      if (ngot != nexp) begin miscompares++; $display("FAIL %s/byte_count: got %0d, want %0d", b_lbl[b], ngot, nexp); end
      nbad = 0; first_bad = -1;
      for (int j = 0; j < ngot && j < nexp; j++)
        if (got_bytes[byte_base + j] !== m_bytes[j]) begin nbad++; if (first_bad < 0) first_bad = j; end
      vectors++;
      if (nbad != 0) begin
        miscompares++;
        $display("FAIL %s/data: byte %0d got %h, want %h (%0d bad)", b_lbl[b], first_bad,
                 got_bytes[byte_base + first_bad], m_bytes[first_bad], nbad);
      end
      if (nexp > 0 && ngot > 0) begin
        nbad = 0; first_bad = -1;
        for (int j = 0; j < ngot && j < nexp; j++) begin
          exp_c = t_start + 32'(m_d) + 2 + 32'(2*j);
          if (got_cyc[byte_base + j] != exp_c) begin nbad++; if (first_bad < 0) first_bad = j; end
        end
        vectors++;
        if (nbad != 0) begin
          miscompares++;
          $display("FAIL %s/byte_timing: byte %0d at cycle %0d, want %0d", b_lbl[b], first_bad,
                   got_cyc[byte_base + first_bad], t_start + 32'(m_d) + 2 + 32'(2*first_bad));
        end
      end
      vectors++;
      if (sof_idx.size() - sof_base != ((nexp > 0) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL %s/sof_count: got %0d, want %0d", b_lbl[b], sof_idx.size() - sof_base, (nexp > 0) ? 1 : 0);
      end else if (nexp > 0) begin
        vectors++;
        if (sof_idx[sof_base] != byte_base) begin
          miscompares++; $display("FAIL %s/sof_pos: got byte %0d, want 0", b_lbl[b], sof_idx[sof_base] - byte_base);
        end
      end
      vectors++;
      if (eof_n - eof_base != int'(m_eof)) begin
        miscompares++; $display("FAIL %s/eof_count: got %0d, want %0d", b_lbl[b], eof_n - eof_base, m_eof);
      end else if (m_eof) begin
        vectors++;
        if (eof_cyc != t_fall + 1) begin
          miscompares++; $display("FAIL %s/eof_timing: got cycle %0d, want %0d", b_lbl[b], eof_cyc, t_fall + 1);
        end
        vectors++;
        if (eof_err !== m_err) begin miscompares++; $display("FAIL %s/rx_err: got %b, want %b", b_lbl[b], eof_err, m_err); end
        vectors++;
        if (int'(eof_len) != m_len) begin miscompares++; $display("FAIL %s/rx_len: got %0d, want %0d", b_lbl[b], eof_len, m_len); end
      end
      vectors++;
      if (good_cnt !== good_m) begin miscompares++; $display("FAIL %s/good_cnt: got %0d, want %0d", b_lbl[b], good_cnt, good_m); end
      vectors++;
      if (bad_cnt !== bad_m) begin miscompares++; $display("FAIL %s/bad_cnt: got %0d, want %0d", b_lbl[b], bad_cnt, bad_m); end
      vectors++;
      if (prot_err != prot_base) begin
        miscompares++; $display("FAIL %s/pulse_overlap: got %0d, want 0", b_lbl[b], prot_err - prot_base);
      end
      for (int g = 1; g < b_gap[b]; g++) @(negedge E_RX_CLK);
    end
  endtask

  task automatic test_reset_midframe();
    int byte_base, eof_base, off, nbad;
    logic [7:0] v;
    logic [3:0] nib;
    byte_base = got_bytes.size();
    eof_base  = eof_n;
    for (int i = 0; i < 16; i++) begin
      @(negedge E_RX_CLK);
      E_RX_DV = 1'b1; E_RX_ER = 1'b0; E_RXD = (i == 15) ? 4'hD : 4'h5;
    end
    for (int j = 0; j < 30; j++) begin
      v = 8'(j);
      @(negedge E_RX_CLK); E_RXD = v[3:0];
      @(negedge E_RX_CLK); E_RXD = v[7:4];
    end
    off = bnib.size();
    for (int p = 0; p < 20; p++) begin
      v   = 8'(30 + p / 2);
      nib = (p % 2 == 1) ? v[7:4] : v[3:0];
      @(negedge E_RX_CLK);
      if (p == 2) RST_N = 1'b1;
      E_RXD = nib;
      if (p >= 2) begin bnib.push_back(nib); ber.push_back(1'b0); end
      if (p == 0) begin
        RST_N = 1'b0;
        #1;
        good_m = '0;
        bad_m  = '0;
        vectors++;
        if ({rx_valid, rx_sof, rx_eof, rx_err} !== 4'b0000) begin
          miscompares++; $display("FAIL reset_mid/flags: got %b, want 0000", {rx_valid, rx_sof, rx_eof, rx_err});
        end
        vectors++;
        if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_mid/rx_data: got %h, want 00", rx_data); end
        vectors++;
        if (rx_len !== 11'd0) begin miscompares++; $display("FAIL reset_mid/rx_len: got %0d, want 0", rx_len); end
        vectors++;
        if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
          miscompares++; $display("FAIL reset_mid/counters: got %0d/%0d, want 0/0", good_cnt, bad_cnt);
        end
      end
    end
    @(negedge E_RX_CLK);
    E_RX_DV = 1'b0; E_RXD = 4'h0;
    @(posedge E_RX_CLK);
    #2;
    model_burst(off, 18);
    good_m = good_m + 16'(m_good);
    bad_m  = bad_m + 16'(m_bad);
    vectors++;
    if (got_bytes.size() - byte_base != 30 + m_bytes.size()) begin
      miscompares++;
      $display("FAIL reset_mid/byte_count: got %0d, want %0d", got_bytes.size() - byte_base, 30 + m_bytes.size());
    end
    nbad = 0;
    for (int j = 0; j < 30 && byte_base + j < got_bytes.size(); j++)
      if (got_bytes[byte_base + j] !== 8'(j)) nbad++;
    vectors++;
    if (nbad != 0) begin miscompares++; $display("FAIL reset_mid/data: got %0d wrong bytes, want 0", nbad); end
    vectors++;
    if (eof_n - eof_base != int'(m_eof)) begin
      miscompares++; $display("FAIL reset_mid/eof_count: got %0d, want %0d", eof_n - eof_base, m_eof);
    end
    vectors++;
    if (bad_cnt !== bad_m) begin miscompares++; $display("FAIL reset_mid/bad_cnt: got %0d, want %0d", bad_cnt, bad_m); end
    vectors++;
    if (good_cnt !== good_m) begin miscompares++; $display("FAIL reset_mid/good_cnt: got %0d, want %0d", good_cnt, good_m); end
    repeat (3) @(negedge E_RX_CLK);
  endtask

  initial begin
    int kind, gap, npre, nbytes, sel, er_at;
    test_reset();

    add_frame("good",      15,   64, 1'b0, -1,      1'b0, 4);
    add_frame("runt",      15,   10, 1'b0, -1,      1'b0, 4);
    add_frame("rx_er",     15,  100, 1'b0, 16 + 40, 1'b0, 4);
    add_frame("dribble",   15,   64, 1'b0, -1,      1'b1, 4);
    add_bad_pre("bad_pre", 1);
    add_frame("after_bad", 15,   64, 1'b1, -1,      1'b0, 4);
    add_frame("zero_byte", 15,    0, 1'b0, -1,      1'b0, 3);
    add_nibs("pre_only",    9, 1'b1, 2);
    add_frame("short_pre",  1,   64, 1'b1, -1,      1'b0, 2);
    add_frame("len63",     15,   63, 1'b1, -1,      1'b0, 2);
    add_frame("len64",     15,   64, 1'b1, -1,      1'b0, 2);
    add_frame("len1518",   15, 1518, 1'b1, -1,      1'b0, 2);
    add_frame("len1519",   15, 1519, 1'b1, -1,      1'b0, 2);
    add_frame("len_sat",   15, 2050, 1'b1, -1,      1'b0, 2);
    add_frame("b2b_a",     15,   64, 1'b1, -1,      1'b0, 1);
    add_frame("b2b_b",     15,   70, 1'b1, -1,      1'b0, 1);
    add_frame("b2b_c",      3,   65, 1'b1, -1,      1'b0, 1);

    for (int r = 0; r < 40; r++) begin
      kind = int'($urandom_range(0, 9));
      gap  = int'($urandom_range(1, 3));
      if (kind == 0) add_nibs("rnd_garbage", int'($urandom_range(1, 8)), 1'b0, gap);
      else if (kind == 1) add_nibs("rnd_pre_only", int'($urandom_range(1, 12)), 1'b1, gap);
      else begin
        npre = int'($urandom_range(1, 15));
        sel  = int'($urandom_range(0, 3));
        if (sel == 0)      nbytes = int'($urandom_range(0, 3));
        else if (sel == 1) nbytes = int'($urandom_range(60, 68));
        else               nbytes = int'($urandom_range(0, 200));
        er_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, npre + 1 + 2 * nbytes)) : -1;
        add_frame("rnd_frame", npre, nbytes, 1'b1, er_at, ($urandom_range(0, 4) == 0), gap);
      end
    end

    test_frame_stream();
    test_reset_midframe();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mii_rx_ctrl.md
# mii_rx_ctrl

Receive-side sequencer for the Ethernet PHY's MII nibble interface. It locks onto preamble/SFD, assembles nibble pairs into bytes, delimits each frame with start/end markers, and classifies frames as good or bad by length, `E_RX_ER` and nibble alignment. It sits directly behind the `E_RX*` pins, in the `E_RX_CLK` domain, and feeds byte-wide frame data and status counters to downstream packet logic and board LEDs.

## Interface
- `MIN_LEN`, 64: minimum good frame length in bytes after SFD, FCS included.
- `MAX_LEN`, 1518: maximum good frame length in bytes after SFD; legal range is 1..2046.
- `E_RX_CLK`  in  1  PHY receive clock (25 MHz at 100 Mb/s). This is the only clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `E_RX_DV`  in  1  receive data valid.
- `E_RXD`  in  4  receive nibble; bit 0 = `E_RXD0`.
- `E_RX_ER`  in  1  PHY receive error (board pin `E_RXD4`).
- `rx_data`  out  8  assembled byte.
- `rx_valid`  out  1  `rx_data` is valid this cycle (one-cycle pulse per byte).
- `rx_sof`  out  1  asserted together with `rx_valid` on the first byte of a frame.
- `rx_eof`  out  1  one-cycle end-of-frame pulse. It never coincides with `rx_valid`.
- `rx_err`  out  1  valid only while `rx_eof` is high. 1 = bad frame.
- `rx_len`  out  11  byte count of the frame. Valid only while `rx_eof` is high.
- `good_cnt`  out  16  count of good frames; wraps.
- `bad_cnt`  out  16  count of bad and aborted frames; wraps.

## Operation
- All inputs are sampled on the rising edge of `E_RX_CLK`. The block has no input register stage.
- States: IDLE, PRE, DATA_LO, DATA_HI, DROP.
- IDLE
  - DV=0: stay.
  - DV=1 and nibble 0x5 → PRE.
  - DV=1 with any other nibble, or with ER=1 → DROP.
- PRE
  - DV=0 → IDLE. Silent: no pulse, no count.
  - ER=1 → DROP.
  - Nibble 0x5: stay.
  - Nibble 0xD → DATA_LO. Clear the length counter and the error flag; arm the sof flag.
  - Any other nibble → DROP.
- DROP
  - Hold until DV=0, then go to IDLE.
  - Increment `bad_cnt` once, on the DV=0 sample.
  - No `rx_sof` and no `rx_eof` are issued.
- DATA_LO
  - DV=1: latch the nibble as the low half → DATA_HI.
  - DV=0: end of an aligned frame → issue eof → IDLE.
- DATA_HI
  - DV=1: `rx_data` <= {nibble, low}; pulse `rx_valid`; pulse `rx_sof` if armed, then disarm; increment the length counter, saturating at 2047 → DATA_LO.
  - DV=0: odd nibble (dribble). Discard the half byte, set the error flag, issue eof → IDLE.
- ER=1 on any sample with DV=1 in DATA_LO or DATA_HI sets the sticky error flag. Byte emission continues.
- Issuing eof means, on the next cycle:
  - `rx_eof`=1 and `rx_len` = length counter.
  - `rx_err` = flag OR len<`MIN_LEN` OR len>`MAX_LEN`.
  - `good_cnt` or `bad_cnt` increments (exactly one of them).
- Bytes beyond `MAX_LEN` are still emitted. The frame is flagged only at eof.
- A zero-byte frame (SFD immediately followed by DV=0) issues `rx_eof` with `rx_err`=1 and `rx_len`=0. It produces no `rx_sof`.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - state = IDLE;
  - `rx_data`=0x00; `rx_valid`, `rx_sof`, `rx_eof`, `rx_err`=0;
  - `rx_len`=0; `good_cnt`, `bad_cnt`=0;
  - internal flags cleared.
- Byte latency: `rx_valid` is high in the cycle after the edge that samples the high nibble. One byte is produced every 2 cycles.
- `rx_eof` is high in the cycle after the first DV=0 sample. The previous `rx_valid` is at least 1 cycle earlier.
- All outputs are registered. `rx_valid`, `rx_sof` and `rx_eof` are single-cycle pulses.
- Back-to-back frames: the block is back in IDLE on the same edge that samples DV=0. A DV=1 sample on the very next edge starts a new frame.
- Reset mid-frame: the frame is abandoned. No eof and no count update. After release, the block waits in IDLE. If DV is still high, the residual nibbles go to DROP and count as one bad frame.
- Counters wrap from 0xFFFF to 0x0000. Simultaneous good/bad increments cannot occur.

## Test plan
- Good frame: 7×0x55 preamble, 0xD5 SFD, 64 bytes 0x00..0x3F, each byte sent low nibble first. Required: 64 `rx_valid` pulses; `rx_sof` on byte 0x00; `rx_eof` with `rx_err`=0 and `rx_len`=64; `good_cnt`=1.
- Runt: same framing with 10 bytes. Required: 10 bytes out; `rx_err`=1, `rx_len`=10; `bad_cnt`=1, `good_cnt` unchanged.
- ER=1 for one cycle during byte 20 of a 100-byte frame. Required: all 100 bytes emitted; `rx_err`=1, `rx_len`=100.
- Dribble: a 64-byte frame plus one extra nibble 0xA. Required: 64 bytes out; `rx_eof` with `rx_err`=1 and `rx_len`=64.
- Bad preamble: 0x5, 0x5, 0x3 … followed by DV low. Required: no `rx_valid`, `rx_sof` or `rx_eof`; `bad_cnt`+1. A good frame sent 1 cycle later is received normally.
- `RST_N` pulsed low mid-frame at byte 30, with DV held for 20 more nibbles. Required: outputs go to 0 immediately; no `rx_eof`; `bad_cnt`=1 after DV falls.
